// File: rtl/load_use_stall_ctrl.sv
// rtl/load_use_stall_ctrl.sv - load-use hazard stall controller with branch-flush gating and stall counter
// Stalls PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles when IF/ID reads a register that the load in ID/EX is still producing.

module load_use_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEXMemRead_i,
  input  logic [REG_AW-1:0] IDEXRegRT_i,
  input  logic [REG_AW-1:0] IFIDRegRS_i,
  input  logic [REG_AW-1:0] IFIDRegRT_i,
  input  logic              IFIDUseRS_i,
  input  logic              IFIDUseRT_i,
  input  logic              BranchFlush_i,
  input  logic              MemStall_i,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IDEXBubble_o,
  output logic              IFIDFlush_o,
  output logic              Stalling_o,
  output logic [CNT_W-1:0]  StallCount_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_count;

  logic w_rs_match;
  logic w_rt_match;
  logic w_hit;
  logic w_stall;
  logic w_advance;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign w_rs_match = IFIDUseRS_i && (IDEXRegRT_i == IFIDRegRS_i);
  assign w_rt_match = IFIDUseRT_i && (IDEXRegRT_i == IFIDRegRT_i);
  assign w_hit      = IDEXMemRead_i && (IDEXRegRT_i != '0) && (w_rs_match || w_rt_match);

  assign w_stall   = (r_state == HOLD) || w_hit;
  assign w_advance = ~MemStall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_stall_count <= '0;
    end else if (w_advance) begin
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_hit && (LOAD_LAT > 1)) begin
            r_state <= HOLD;
            r_cnt   <= LAT_M1;
          end
        end
        HOLD: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // A frozen pipeline must not move anything, so memory busy masks every enable and the flush.
  always_comb begin
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IDEXBubble_o = 1'b0;
    IFIDFlush_o  = 1'b0;
    Stalling_o   = 1'b0;
    if (!rst_i) begin
      Stalling_o = w_stall;
      if (MemStall_i) begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else begin
        PCWrite_o    = ~w_stall;
        IFIDWrite_o  = ~w_stall;
        IDEXBubble_o = w_stall;
        IFIDFlush_o  = BranchFlush_i & ~w_stall;
      end
    end
  end

  assign StallCount_o = r_stall_count;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// tb/tb_load_use_stall_ctrl.sv - directed self-checking bench for load_use_stall_ctrl
// Three instances (LOAD_LAT=1, LOAD_LAT=3, LOAD_LAT=5 with CNT_W=2) share one stimulus stream.

module tb_load_use_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       use_rs;
  logic       use_rt;
  logic       br_flush;
  logic       mem_stall;

  logic        pcw1, ifw1, bub1, fl1, st1;
  logic [15:0] cnt1;
  logic        pcw3, ifw3, bub3, fl3, st3;
  logic [15:0] cnt3;
  logic        pcw5, ifw5, bub5, fl5, st5;
  logic [1:0]  cnt5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .IDEXMemRead_i(mem_rd), .IDEXRegRT_i(ex_rt),
    .IFIDRegRS_i(id_rs), .IFIDRegRT_i(id_rt), .IFIDUseRS_i(use_rs), .IFIDUseRT_i(use_rt),
    .BranchFlush_i(br_flush), .MemStall_i(mem_stall),
    .PCWrite_o(pcw1), .IFIDWrite_o(ifw1), .IDEXBubble_o(bub1), .IFIDFlush_o(fl1),
    .Stalling_o(st1), .StallCount_o(cnt1)
  );

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .IDEXMemRead_i(mem_rd), .IDEXRegRT_i(ex_rt),
    .IFIDRegRS_i(id_rs), .IFIDRegRT_i(id_rt), .IFIDUseRS_i(use_rs), .IFIDUseRT_i(use_rt),
    .BranchFlush_i(br_flush), .MemStall_i(mem_stall),
    .PCWrite_o(pcw3), .IFIDWrite_o(ifw3), .IDEXBubble_o(bub3), .IFIDFlush_o(fl3),
    .Stalling_o(st3), .StallCount_o(cnt3)
  );

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(5), .CNT_W(2)) u_lat5 (
    .clk_i(clk), .rst_i(rst), .IDEXMemRead_i(mem_rd), .IDEXRegRT_i(ex_rt),
    .IFIDRegRS_i(id_rs), .IFIDRegRT_i(id_rt), .IFIDUseRS_i(use_rs), .IFIDUseRT_i(use_rt),
    .BranchFlush_i(br_flush), .MemStall_i(mem_stall),
    .PCWrite_o(pcw5), .IFIDWrite_o(ifw5), .IDEXBubble_o(bub5), .IFIDFlush_o(fl5),
    .Stalling_o(st5), .StallCount_o(cnt5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    mem_rd = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    use_rs = 1'b0; use_rt = 1'b0; br_flush = 1'b0; mem_stall = 1'b0;
  endtask

  // Load to r8 in ID/EX, IF/ID reads rs=r8.
  task automatic hit_in();
    mem_rd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; use_rs = 1'b1;
    id_rt = 5'd3; use_rt = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    hit_in();
    br_flush = 1'b1;
    #2;
    // Outputs forced while reset is held, even with a hit and a flush request.
    check("rst_pcw", pcw1, 1'b1);
    check("rst_ifw", ifw3, 1'b1);
    check("rst_bub", bub1, 1'b0);
    check("rst_flush", fl3, 1'b0);
    check("rst_stall", st5, 1'b0);
    check("rst_cnt", cnt3, 16'd0);
    step();
    clear_in();
    rst = 1'b0;
    step();

    // LOAD_LAT=1 single bubble.
    hit_in();
    #1;
    check("l1_pcw", pcw1, 1'b0);
    check("l1_ifw", ifw1, 1'b0);
    check("l1_bub", bub1, 1'b1);
    check("l1_stall", st1, 1'b1);
    step();
    clear_in();
    #1;
    check("l1_release_pcw", pcw1, 1'b1);
    check("l1_release_bub", bub1, 1'b0);
    check("l1_cnt", cnt1, 16'd1);

    // No-hazard patterns on the LOAD_LAT=1 instance.
    mem_rd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; use_rs = 1'b1;
    #1 check("r0_nostall", st1, 1'b0);
    ex_rt = 5'd9; id_rt = 5'd9; use_rt = 1'b0; id_rs = 5'd3;
    #1 check("rt_unused_nostall", st1, 1'b0);
    use_rt = 1'b1;
    #1 check("rt_used_stall", st1, 1'b1);
    mem_rd = 1'b0;
    #1 check("not_load_nostall", st1, 1'b0);
    step();
    check("nohit_cnt_unchanged", cnt1, 16'd1);
    clear_in();

    // LOAD_LAT=3: three stall cycles, then same-cycle re-entry.
    pulse_reset();
    check("areset_cnt1", cnt1, 16'd0);
    step();
    hit_in();
    #1 check("l3_c1_stall", st3, 1'b1);
    step();
    clear_in();
    #1 check("l3_c2_stall", st3, 1'b1);
    check("l3_c2_pcw", pcw3, 1'b0);
    step();
    #1 check("l3_c3_stall", st3, 1'b1);
    step();
    #1 check("l3_release", st3, 1'b0);
    check("l3_release_pcw", pcw3, 1'b1);
    check("l3_cnt", cnt3, 16'd3);
    hit_in();
    ex_rt = 5'd12; id_rs = 5'd12;
    #1 check("l3_reentry", st3, 1'b1);
    clear_in();

    // Branch flush suppressed for 3 stall cycles, taken on the 4th.
    pulse_reset();
    step();
    hit_in();
    br_flush = 1'b1;
    #1 check("br_c1_flush", fl3, 1'b0);
    step();
    mem_rd = 1'b0;
    #1 check("br_c2_flush", fl3, 1'b0);
    step();
    #1 check("br_c3_flush", fl3, 1'b0);
    step();
    #1 check("br_c4_flush", fl3, 1'b1);
    clear_in();

    // MemStall for 2 cycles inside HOLD: 5 stall cycles, count 3.
    pulse_reset();
    step();
    hit_in();
    #1 check("ms_c1_stall", st3, 1'b1);
    step();
    clear_in();
    #1 check("ms_c2_stall", st3, 1'b1);
    step();
    mem_stall = 1'b1;
    #1 check("ms_c3_stall", st3, 1'b1);
    check("ms_c3_bub", bub3, 1'b0);
    check("ms_c3_pcw", pcw3, 1'b0);
    step();
    #1 check("ms_c4_stall", st3, 1'b1);
    check("ms_c4_cnt_frozen", cnt3, 16'd2);
    step();
    mem_stall = 1'b0;
    #1 check("ms_c5_stall", st3, 1'b1);
    check("ms_c5_bub", bub3, 1'b1);
    step();
    #1 check("ms_release", st3, 1'b0);
    check("ms_cnt", cnt3, 16'd3);

    // Asynchronous reset mid-HOLD.
    pulse_reset();
    step();
    hit_in();
    step();
    clear_in();
    #1 check("mid_hold_stall", st3, 1'b1);
    #1 rst = 1'b1;
    hit_in();
    #1;
    check("mid_rst_stall", st3, 1'b0);
    check("mid_rst_pcw", pcw3, 1'b1);
    check("mid_rst_cnt", cnt3, 16'd0);
    clear_in();
    #1 rst = 1'b0;
    step();
    #1 check("post_rst_idle", st3, 1'b0);

    // CNT_W=2 with five stall cycles saturates at 3.
    pulse_reset();
    step();
    hit_in();
    #1 check("sat_c1_stall", st5, 1'b1);
    step();
    clear_in();
    for (int i = 2; i <= 5; i++) begin
      #1 check($sformatf("sat_c%0d_stall", i), st5, 1'b1);
      step();
    end
    #1 check("sat_release", st5, 1'b0);
    check("sat_cnt", cnt5, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_use_stall_ctrl.md
# load_use_stall_ctrl

Parametrised load-use hazard controller for the 5-stage pipeline. It sits beside the ID stage and compares the instruction in IF/ID against a load in ID/EX. On a match it stalls PC and IF/ID for a configurable number of cycles and bubbles ID/EX. It also gates the ID-stage branch flush and freezes on data-memory busy. The block also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, stall cycles per load-use hazard (legal 1..15); 1 reproduces the classic single-bubble stall.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- IDEXMemRead_i  in  1  the instruction in ID/EX is a load.
- IDEXRegRT_i  in  REG_AW  destination register of that load.
- IFIDRegRS_i  in  REG_AW  rs field of the instruction in IF/ID.
- IFIDRegRT_i  in  REG_AW  rt field of the instruction in IF/ID.
- IFIDUseRS_i  in  1  the instruction in IF/ID reads rs.
- IFIDUseRT_i  in  1  the instruction in IF/ID reads rt.
- BranchFlush_i  in  1  branch resolved taken in ID; requests an IF/ID flush.
- MemStall_i  in  1  data memory busy; the whole pipeline freezes.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register update enable.
- IDEXBubble_o  out  1  zero the control signals entering ID/EX.
- IFIDFlush_o  out  1  flush IF/ID (gated branch flush).
- Stalling_o  out  1  a load-use stall is in effect this cycle.
- StallCount_o  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Hit condition, evaluated combinationally: IDEXMemRead_i=1, IDEXRegRT_i != 0, and at least one of the following:
  - IFIDUseRS_i=1 and IDEXRegRT_i==IFIDRegRS_i
  - IFIDUseRT_i=1 and IDEXRegRT_i==IFIDRegRT_i
- Register 0 never causes a hazard.
- FSM has two states, IDLE and HOLD, plus a down-counter cnt of 4 bits.
- In IDLE, stall = hit.
  - If hit, MemStall_i=0 and LOAD_LAT>1: next state is HOLD with cnt=LOAD_LAT-1.
  - Otherwise the state stays IDLE.
- In HOLD, stall=1 regardless of hit (ID/EX now holds a bubble).
  - If MemStall_i=0, cnt decrements.
  - When cnt==1 and it decrements, next state is IDLE.
- Outputs when MemStall_i=0:
  - PCWrite_o = IFIDWrite_o = ~stall
  - IDEXBubble_o = stall
  - Stalling_o = stall
  - IFIDFlush_o = BranchFlush_i & ~stall. A branch whose operands depend on the load is not valid yet, so its flush is suppressed until the stall ends.
- Outputs when MemStall_i=1:
  - PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=0, IFIDFlush_o=0.
  - Stalling_o still reflects stall.
  - FSM state and cnt hold; StallCount_o does not increment.
- StallCount_o increments by 1 on each edge where stall=1 and MemStall_i=0. It saturates at 2^CNT_W-1 with no wrap.
- rst_i asserted, at any point including mid-HOLD:
  - Immediately forces state IDLE, cnt 0, StallCount_o 0.
  - While rst_i=1, outputs are forced to PCWrite_o=1, IFIDWrite_o=1, IDEXBubble_o=0, IFIDFlush_o=0, Stalling_o=0, independent of the other inputs.

## Timing
- Hazard outputs are combinational from the inputs and state, with zero-cycle latency to the hit.
- A hit with LOAD_LAT=N gives exactly N consecutive stall cycles, excluding any cycles frozen by MemStall_i.
- Re-entry: on the first IDLE cycle after HOLD, a new hit (a different load now in ID/EX) starts a new stall in that same cycle.
- A hit and BranchFlush_i in the same cycle: stall wins and IFIDFlush_o=0. The flush is taken in the first non-stall cycle if BranchFlush_i is still asserted.
- MemStall_i rising mid-HOLD extends the stall by the frozen cycles. The counter resumes where it stopped.

## Test plan
- LOAD_LAT=1; load to r8 in ID/EX; IF/ID reads rs=r8 with UseRS=1 -> one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, then idle values; StallCount_o=1.
- LOAD_LAT=3, same stimulus -> exactly 3 stall cycles (IDLE, then HOLD with cnt 2->1), then release; StallCount_o=3.
- Load to r0, or match on rt with UseRT=0 -> no stall; StallCount_o unchanged.
- LOAD_LAT=3: hit plus BranchFlush_i=1 held for 4 cycles -> IFIDFlush_o=0 for 3 cycles, then 1 on the 4th; MemStall_i=1 for 2 cycles inside HOLD -> stall lasts 5 cycles and StallCount_o=3.
- rst_i pulsed in the middle of HOLD, asynchronously -> outputs return to idle values immediately and StallCount_o=0. CNT_W=2 with 5 stall cycles -> StallCount_o saturates at 3.
